// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32 instruction encoder.
// The master side supplies requests and consumes words; the slave side is the encoder.
interface instr_encoder_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          req_valid_i;
   logic          req_ready_o;
   logic [1:0]    type_i;
   logic [3:0]    op_i;
   logic [4:0]    rd_i;
   logic [4:0]    rs1_i;
   logic [4:0]    rs2_i;
   logic [11:0]   imm_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [31:0]   instr_o;
   logic [31:0]   addr_o;
   logic          err_o;
   logic [CW-1:0] count_o;

   modport master (
      output req_valid_i, type_i, op_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
      input  req_ready_o, out_valid_o, instr_o, addr_o, err_o, count_o
   );

   modport slave (
      input  req_valid_i, type_i, op_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
      output req_ready_o, out_valid_o, instr_o, addr_o, err_o, count_o
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes R-type / I-type arithmetic requests into RV32 words and queues them
// in a small FIFO; each popped word carries a running byte address.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 4
) (
   input logic           clk_i,
   input logic           rst_i,
   instr_encoder_if.slave bus
);
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;
   localparam logic [6:0]  OPC_R = 7'b0110011;
   localparam logic [6:0]  OPC_I = 7'b0010011;

   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   addr_q, addr_d;
   logic          err_q, err_d;

   logic          legal;
   logic [31:0]   word;
   logic          ready;
   logic          valid;
   logic          accept;
   logic          push;
   logic          pop;

   // Ready/valid depend only on registered occupancy.
   assign ready  = (count_q < CW'(DEPTH));
   assign valid  = (count_q != '0);
   assign accept = bus.req_valid_i && ready;
   assign push   = accept && legal;
   assign pop    = valid && bus.out_ready_i;

   assign bus.req_ready_o = ready;
   assign bus.out_valid_o = valid;
   assign bus.count_o     = count_q;
   assign bus.addr_o      = addr_q;
   assign bus.err_o       = err_q;
   // Memory is not reset; masking with valid gives a zero word while empty/in reset.
   assign bus.instr_o     = valid ? mem_q[rd_ptr_q] : '0;

   // Decode the request into an RV32 word and a legality flag.
   always_comb begin
      legal = 1'b0;
      word  = '0;
      case (bus.type_i)
         2'b00: begin
            legal = 1'b1;
            case (bus.op_i)
               4'd0:    word = {7'b0000000, bus.rs2_i, bus.rs1_i, 3'b111, bus.rd_i, OPC_R};
               4'd1:    word = {7'b0000000, bus.rs2_i, bus.rs1_i, 3'b100, bus.rd_i, OPC_R};
               4'd2:    word = {7'b0000000, bus.rs2_i, bus.rs1_i, 3'b001, bus.rd_i, OPC_R};
               4'd3:    word = {7'b0000000, bus.rs2_i, bus.rs1_i, 3'b000, bus.rd_i, OPC_R};
               4'd4:    word = {7'b0100000, bus.rs2_i, bus.rs1_i, 3'b000, bus.rd_i, OPC_R};
               4'd5:    word = {7'b0000001, bus.rs2_i, bus.rs1_i, 3'b000, bus.rd_i, OPC_R};
               default: legal = 1'b0;
            endcase
         end
         2'b01: begin
            legal = 1'b1;
            case (bus.op_i)
               4'd0:    word = {bus.imm_i, bus.rs1_i, 3'b000, bus.rd_i, OPC_I};
               4'd1:    word = {7'b0100000, bus.imm_i[4:0], bus.rs1_i, 3'b101, bus.rd_i, OPC_I};
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
   end

   // Next-state for FIFO pointers, occupancy, output address and error pulse.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      addr_d   = addr_q;
      err_d    = accept && !legal;
      if (push) begin
         mem_d[wr_ptr_q] = word;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         addr_d   = addr_q + 32'd4;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= BASE_ADDR;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         err_q    <= err_d;
      end
   end

   // FIFO storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end
endmodule
